serializer_param: RTL and testbench
===================================

# serializer_param

Parametrised successor of the 16-bit serializer: converts a parallel word of `DATA_W` bits into a serial bit stream of programmable length, one bit per clock. Additions over the previous generation:
- a one-word holding register, so consecutive words stream with no idle cycle;
- per-word bit order selection;
- a last-bit marker.

It sits between a parallel producer and a bit-serial link or encoder in the same clock domain.

## Interface
Parameters:
- `DATA_W`, 16, input word width; legal values ≥ 4, power of two.
- `MIN_LEN`, 3, shortest legal burst; words whose length is below this are dropped.
- `MOD_W`, `$clog2(DATA_W)`, derived width of `data_mod_i`; not to be overridden.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `srst_i`  in  1  reset; one clock, reset is synchronous and active-high.
- `data_i`  in  `DATA_W`  parallel word.
- `data_mod_i`  in  `MOD_W`  burst length in bits; 0 means `DATA_W` bits.
- `msb_first_i`  in  1  bit order for this word: 1 = MSB first, 0 = LSB first.
- `data_val_i`  in  1  word valid; sampled only when `busy_o` is 0.
- `ser_data_o`  out  1  serial bit; 0 whenever `ser_data_val_o` is 0.
- `ser_data_val_o`  out  1  serial bit valid.
- `ser_last_o`  out  1  high with the last bit of each burst.
- `busy_o`  out  1  high while the holding register is occupied; input is not accepted.

## Operation
Datapath:
- Shifter: holds the word currently being emitted, plus a bit counter.
- Hold: one-entry buffer for a single pending word, with a full flag.

Accept and length:
- Acceptance happens when `data_val_i && !busy_o`.
- `len` = `DATA_W` if `data_mod_i == 0`, else `data_mod_i`.
- An accepted word with `len < MIN_LEN` is consumed and discarded. It produces no output and occupies neither the shifter nor the hold register.

Routing of a legal word:
- The word goes to the shifter if the shifter is free next cycle (idle, or emitting its last bit this cycle) and the hold register is empty.
- Otherwise it goes to the hold register and `busy_o` rises.

Bit order:
- MSB-first emits `data[DATA_W-1]` down to `data[DATA_W-len]`.
- LSB-first emits `data[0]` up to `data[len-1]`.
- `msb_first_i` and `len` are captured with the word. Later input changes do not affect words already captured.

Hold transfer:
- When the shifter emits its last bit and the hold register is full, hold moves into the shifter at that edge and the hold register empties.
- `busy_o` falls in the cycle after the transfer.

State machine:
- IDLE → SHIFT on a load.
- SHIFT → SHIFT on the last bit if a word is held, or on a direct load during the last bit.
- SHIFT → IDLE on the last bit with nothing pending.

Reset:
- `srst_i` aborts any burst immediately and discards the held word.
- The next cycle all outputs are 0 and the block is IDLE.
- `data_val_i` in the reset cycle is ignored.

## Timing
Reset values:
- `ser_data_o`, `ser_data_val_o`, `ser_last_o` and `busy_o` are 0.
- All outputs are registered.

Latency:
- A word accepted at edge N into an idle shifter produces its first bit at cycle N+1.
- Bits follow on `len` consecutive cycles; `ser_last_o` is high on cycle N+len.

Throughput:
- Back-to-back legal words give continuous `ser_data_val_o` with no gap.
- A word presented during the last-bit cycle, with hold empty, starts on the very next cycle.

Busy:
- `busy_o` rises the cycle after a word is written into the hold register.
- While `busy_o` is 1, `data_val_i` is ignored and that word is lost. Producers must hold the word or wait.

Simultaneous events:
- Last bit, hold full and a new `data_val_i`: `busy_o` was 1 in that cycle, so the new word is ignored.
- Dropped short word (`len < MIN_LEN`) while the shifter is busy: no effect on the stream or on `busy_o`.

## Test plan
- `DATA_W`=16, `data_i`=0xA5C3, mod 0, MSB-first → 16 bits 1010010111000011 on cycles N+1..N+16; `ser_last_o` only at N+16; `busy_o` stays 0.
- 0x00F3, mod 5, LSB-first → bits 1,1,0,0,1; valid for exactly 5 cycles.
- Mod 1 and mod 2 words → no `ser_data_val_o`, `busy_o` stays 0. A following mod-3 word streams normally.
- Three 16-bit words presented on consecutive accepted cycles → 48 contiguous valid bits in order, `busy_o` high while a word is held, third word accepted only after `busy_o` falls.
- `srst_i` asserted at bit 7 of a burst with a word held → all outputs 0 the next cycle; neither word resumes; a new word after reset streams from its first bit.
- `DATA_W`=8: random mods 0..7 with random bit order, checked against a reference model over 1000 words → bit-exact, `ser_last_o` count equals the number of words with `len` ≥ 3.

Source files
------------

// File: rtl/serializer_param.sv
// Parallel-to-serial converter with programmable burst length,
// per-word bit order, last-bit marker and a one-word holding register.
module serializer_param #(
  parameter int DATA_W  = 16,
  parameter int MIN_LEN = 3,
  parameter int MOD_W   = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o
);

  localparam int LEN_W = MOD_W + 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [DATA_W-1:0] r_sh_data;
  logic [LEN_W-1:0]  r_sh_cnt;
  logic              r_sh_msb;

  logic [DATA_W-1:0] r_hold_data;
  logic [LEN_W-1:0]  r_hold_len;
  logic              r_hold_msb;
  logic              r_hold_full;

  logic r_ser_data;
  logic r_ser_val;
  logic r_ser_last;

  logic [LEN_W-1:0] w_len;
  logic             w_legal;
  logic             w_take;
  logic             w_free;
  logic             w_ld_hold;
  logic             w_ld_in;
  logic             w_load;
  logic             w_shift;
  logic             w_to_hold;

  logic [DATA_W-1:0] w_src_data;
  logic [LEN_W-1:0]  w_src_len;
  logic              w_src_msb;

  logic [DATA_W-1:0] w_sh_data_nx;
  logic [LEN_W-1:0]  w_sh_cnt_nx;
  logic              w_sh_msb_nx;
  logic              w_bit_nx;
  logic              w_val_nx;
  logic              w_last_nx;

  assign w_len = (data_mod_i == '0) ? LEN_W'(DATA_W)
                                    : {1'b0, data_mod_i};
  assign w_legal = (w_len >= LEN_W'(MIN_LEN));

  // busy_o is exactly the hold-full flag, so acceptance gates on it
  assign w_take = data_val_i && !r_hold_full && w_legal;

  // shifter can take a word at this edge: idle or on its last bit
  assign w_free    = (r_state == S_IDLE) || r_ser_last;
  assign w_ld_hold = w_free && r_hold_full;
  assign w_ld_in   = w_free && !r_hold_full && w_take;
  assign w_load    = w_ld_hold || w_ld_in;
  assign w_to_hold = !w_free && w_take;
  assign w_shift   = (r_state == S_SHIFT) && !r_ser_last;

  assign w_src_data = r_hold_full ? r_hold_data : data_i;
  assign w_src_len  = r_hold_full ? r_hold_len  : w_len;
  assign w_src_msb  = r_hold_full ? r_hold_msb  : msb_first_i;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_load) w_state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_load)          w_state_nx = S_SHIFT;
        else if (r_ser_last) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // first bit leaves on the load edge; the shifter keeps the rest
  always_comb begin
    w_sh_data_nx = r_sh_data;
    w_sh_cnt_nx  = r_sh_cnt;
    w_sh_msb_nx  = r_sh_msb;
    w_bit_nx     = 1'b0;
    w_val_nx     = 1'b0;
    w_last_nx    = 1'b0;
    unique case (1'b1)
      w_load: begin
        w_bit_nx     = w_src_msb ? w_src_data[DATA_W-1]
                                 : w_src_data[0];
        w_sh_data_nx = w_src_msb ? (w_src_data << 1)
                                 : (w_src_data >> 1);
        w_sh_cnt_nx  = w_src_len - LEN_W'(1);
        w_sh_msb_nx  = w_src_msb;
        w_val_nx     = 1'b1;
        w_last_nx    = (w_src_len == LEN_W'(1));
      end
      w_shift: begin
        w_bit_nx     = r_sh_msb ? r_sh_data[DATA_W-1]
                                : r_sh_data[0];
        w_sh_data_nx = r_sh_msb ? (r_sh_data << 1)
                                : (r_sh_data >> 1);
        w_sh_cnt_nx  = r_sh_cnt - LEN_W'(1);
        w_val_nx     = 1'b1;
        w_last_nx    = (r_sh_cnt == LEN_W'(1));
      end
      default: begin
        w_sh_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_sh_data  <= '0;
      r_sh_cnt   <= '0;
      r_sh_msb   <= 1'b0;
      r_ser_data <= 1'b0;
      r_ser_val  <= 1'b0;
      r_ser_last <= 1'b0;
    end else begin
      r_sh_data  <= w_sh_data_nx;
      r_sh_cnt   <= w_sh_cnt_nx;
      r_sh_msb   <= w_sh_msb_nx;
      r_ser_data <= w_bit_nx;
      r_ser_val  <= w_val_nx;
      r_ser_last <= w_last_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_hold_data <= '0;
      r_hold_len  <= '0;
      r_hold_msb  <= 1'b0;
      r_hold_full <= 1'b0;
    end else if (w_to_hold) begin
      r_hold_data <= data_i;
      r_hold_len  <= w_len;
      r_hold_msb  <= msb_first_i;
      r_hold_full <= 1'b1;
    end else if (w_ld_hold) begin
      r_hold_full <= 1'b0;
    end
  end

  assign ser_data_o     = r_ser_data;
  assign ser_data_val_o = r_ser_val;
  assign ser_last_o     = r_ser_last;
  assign busy_o         = r_hold_full;

endmodule

// File: tb/tb_serializer_param.sv
// Scoreboard bench for serializer_param (DATA_W=16).
// Driver queues expected bits on accept; negedge monitor compares.
module tb_serializer_param;

  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          srst_i;
  logic [DW-1:0] data_i;
  logic [MW-1:0] data_mod_i;
  logic          msb_first_i;
  logic          data_val_i;
  logic          ser_data_o;
  logic          ser_data_val_o;
  logic          ser_last_o;
  logic          busy_o;

  always #5 clk = ~clk;

  serializer_param #(
    .DATA_W (DW),
    .MIN_LEN(3)
  ) dut (
    .clk_i         (clk),
    .srst_i        (srst_i),
    .data_i        (data_i),
    .data_mod_i    (data_mod_i),
    .msb_first_i   (msb_first_i),
    .data_val_i    (data_val_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .ser_last_o    (ser_last_o),
    .busy_o        (busy_o)
  );

  typedef struct packed {
    logic d;
    logic l;
  } sb_t;

  sb_t q[$];
  int  checks = 0;
  int  fails = 0;
  bit  mon_en = 0;
  int  busy_cyc = 0;
  int  last_cnt = 0;
  int  val_cyc = 0;
  int  legal_words = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      sb_t e;
      if (busy_o === 1'b1) busy_cyc++;
      checks++;
      if (ser_data_val_o !== (q.size() != 0)) begin
        fails++;
        $display("FAIL valid_align: val=%b expected=%b t=%0t",
                 ser_data_val_o, (q.size() != 0), $time);
      end
      if (ser_data_val_o === 1'b1) begin
        val_cyc++;
        if (ser_last_o === 1'b1) last_cnt++;
        if (q.size() != 0) begin
          e = q.pop_front();
          checks++;
          if ({ser_data_o, ser_last_o} !== {e.d, e.l}) begin
            fails++;
            $display("FAIL bit: data/last=%b%b expected=%b%b t=%0t",
                     ser_data_o, ser_last_o, e.d, e.l, $time);
          end
        end
      end else begin
        checks++;
        if (ser_data_o !== 1'b0 || ser_last_o !== 1'b0) begin
          fails++;
          $display("FAIL idle_zero: data=%b last=%b expected 0 0",
                   ser_data_o, ser_last_o);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void push(input logic [DW-1:0] d,
                               input logic [MW-1:0] m,
                               input logic msb);
    int   len;
    sb_t  e;
    len = (m == 0) ? DW : int'(m);
    if (len >= 3) begin
      legal_words++;
      for (int i = 0; i < len; i++) begin
        e.d = msb ? d[DW-1-i] : d[i];
        e.l = (i == len - 1);
        q.push_back(e);
      end
    end
  endfunction

  // called #1 after an edge; returns #1 after the accepting edge
  task automatic send(input logic [DW-1:0] d,
                      input logic [MW-1:0] m,
                      input logic msb);
    int t = 0;
    while (busy_o !== 1'b0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      fails++;
      $display("FAIL busy_timeout: busy=%b expected 0", busy_o);
    end
    data_i      = d;
    data_mod_i  = m;
    msb_first_i = msb;
    data_val_i  = 1'b1;
    @(posedge clk);
    push(d, m, msb);
    #1;
    data_val_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) begin
      fails++;
      $display("FAIL drain_timeout: left=%0d expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  int b0, l0, v0, w0;

  initial begin
    srst_i      = 1'b1;
    data_i      = '0;
    data_mod_i  = '0;
    msb_first_i = 1'b0;
    data_val_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    srst_i = 1'b0;
    chk("rst_val", int'(ser_data_val_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_last", int'(ser_last_o), 0);
    chk("rst_data", int'(ser_data_o), 0);
    mon_en = 1;

    // full 16-bit MSB-first word
    b0 = busy_cyc; l0 = last_cnt; v0 = val_cyc;
    send(16'hA5C3, 4'd0, 1'b1);
    drain();
    chk("w16_busy", busy_cyc - b0, 0);
    chk("w16_last", last_cnt - l0, 1);
    chk("w16_len", val_cyc - v0, 16);

    // 5-bit LSB-first word
    v0 = val_cyc;
    send(16'h00F3, 4'd5, 1'b0);
    drain();
    chk("w5_len", val_cyc - v0, 5);

    // short words dropped, then a 3-bit word
    b0 = busy_cyc; v0 = val_cyc; l0 = last_cnt;
    send(16'hFFFF, 4'd1, 1'b1);
    send(16'hFFFF, 4'd2, 1'b0);
    send(16'hA000, 4'd3, 1'b1);
    drain();
    chk("short_busy", busy_cyc - b0, 0);
    chk("short_len", val_cyc - v0, 3);
    chk("short_last", last_cnt - l0, 1);

    // three words back to back
    b0 = busy_cyc; v0 = val_cyc; l0 = last_cnt;
    send(16'h1234, 4'd0, 1'b1);
    send(16'hBEEF, 4'd0, 1'b0);
    chk("b2b_busy_up", int'(busy_o), 1);
    send(16'h0F0F, 4'd0, 1'b1);
    drain();
    chk("b2b_len", val_cyc - v0, 48);
    chk("b2b_last", last_cnt - l0, 3);
    checks++;
    if (busy_cyc - b0 < 2) begin
      fails++;
      $display("FAIL b2b_busy_cyc: got=%0d expected>=2", busy_cyc - b0);
    end

    // short word while shifter busy: no hold, no busy
    send(16'h5555, 4'd0, 1'b0);
    send(16'hFFFF, 4'd2, 1'b1);
    chk("drop_busy", int'(busy_o), 0);
    send(16'h8001, 4'd4, 1'b0);
    chk("after_drop_busy", int'(busy_o), 1);
    drain();

    // reset mid-burst with a held word
    send(16'hC3A5, 4'd0, 1'b1);
    send(16'h7777, 4'd0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    srst_i     = 1'b1;
    data_val_i = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    srst_i     = 1'b0;
    data_val_i = 1'b0;
    chk("srst_val", int'(ser_data_val_o), 0);
    chk("srst_busy", int'(busy_o), 0);
    chk("srst_last", int'(ser_last_o), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("srst_quiet", q.size() + int'(ser_data_val_o), 0);

    // reset while idle with a valid word presented
    srst_i      = 1'b1;
    data_val_i  = 1'b1;
    data_mod_i  = 4'd0;
    @(posedge clk);
    #1;
    srst_i     = 1'b0;
    data_val_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("srst_ignore", int'(ser_data_val_o), 0);

    send(16'h9C31, 4'd7, 1'b0);
    drain();

    // random words with random gaps
    l0 = last_cnt; w0 = legal_words;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    chk("rand_last", last_cnt - l0, legal_words - w0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
